fft_butterfly_sched: RTL and testbench
======================================

// Module: fft_butterfly_sched
// PURPOSE
//  Sequential butterfly address scheduler for an in-place radix-2 FFT of SAMPLES points.
//  Walks every stage and emits one butterfly per accepted beat: operand indices A/B,
//  twiddle index, stage number and end-of-stage/end-of-transform flags.
//  Successor to the static single-stage pair-index table; it sits between the FFT
//  controller and the sample RAM / twiddle ROM address ports.
//  Adds run-time sequencing over all stages, DIT/DIF stage order, valid/ready
//  back-pressure and abort.
// PARAMETERS
//  SAMPLES  16  transform length; power of two, >= 2
//  MODE     0   0 = stages ascending 0..LOG2-1 (DIT), 1 = descending LOG2-1..0 (DIF)
//  Derived:
//   LOG2  = $clog2(SAMPLES)
//   IDX_W = max(1,LOG2)
//   TW_W  = max(1,LOG2-1)
//   STG_W = max(1,$clog2(LOG2))
// PORTS
//  clk            in   1      single clock, all logic on posedge
//  rst            in   1      synchronous, active-high reset
//  start          in   1      request a full transform schedule; honoured only in IDLE
//  abort          in   1      terminate current schedule; no done pulse
//  out_valid      out  1      A/B/tw/stage fields valid
//  out_ready      in   1      downstream accepts beat when out_valid&&out_ready
//  idx_a          out  IDX_W  butterfly upper operand index
//  idx_b          out  IDX_W  lower operand index = idx_a + (1<<stage)
//  tw_idx         out  TW_W   twiddle index = j << (LOG2-1-stage)
//  stage          out  STG_W  current stage number
//  last_in_stage  out  1      beat is the final butterfly of its stage
//  last           out  1      beat is the final butterfly of the transform
//  busy           out  1      high in RUN
//  done           out  1      one-cycle pulse after final beat accepted
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0. A reset asserted mid-run discards the schedule.
//  - FSM states IDLE, RUN, DONE.
//    IDLE --start--> RUN
//    RUN --last beat accepted--> DONE
//    RUN --abort--> IDLE
//    DONE --(1 cycle)--> IDLE
//  - start seen in IDLE at edge T: at T+1 out_valid=1 with the first beat; all outputs
//    are registered.
//  - start is ignored in RUN and DONE; it is not queued.
//  - Per stage s, pair counter p runs 0..SAMPLES/2-1:
//    j = p & ((1<<s)-1)
//    idx_a = p with a 0 inserted at bit s, i.e. ((p>>s)<<(s+1)) | j
//    idx_b = idx_a | (1<<s)
//  - Ordering inside a stage: groups ascending, j ascending within a group.
//  - A beat is one handshake. With valid high and ready low, all fields are held stable.
//  - One beat per cycle maximum. Total beats = (SAMPLES/2)*LOG2.
//  - last_in_stage is high when p==SAMPLES/2-1.
//  - last is high when last_in_stage is high and stage is the final stage of MODE's order.
//  - On acceptance of the last beat: out_valid=0 and done=1 next cycle, then IDLE.
//  - abort has priority over a handshake in the same cycle:
//    * next cycle out_valid=0, busy=0, done=0
//    * the beat presented that cycle counts as not delivered
//  - abort in IDLE or DONE has no effect; the done pulse is not suppressed.
//  - busy=1 in RUN only; done=1 in DONE only.
//  - SAMPLES=2: single stage 0, single beat (0,1), tw 0, last_in_stage=last=1.
//  - No arithmetic overflow: idx_b < SAMPLES by construction; the counter wraps only
//    at a stage boundary.
// TESTING
//  1. SAMPLES=8, MODE=0, ready=1, start pulse. Beats on consecutive cycles:
//     - stage 0: (0,1)(2,3)(4,5)(6,7), tw 0
//     - stage 1: (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2
//     - stage 2: (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3
//     Expect last_in_stage on beats 4,8,12; last on beat 12; done the cycle after.
//  2. SAMPLES=8, MODE=1, ready=1: stage order 2,1,0 with the same per-stage lists as
//     test 1; last on (6,7).
//  3. Back-pressure: ready=0 for 3 cycles on beat (1,3). Expect fields held, no skip,
//     no duplicate; 12 beats total.
//  4. abort asserted with ready=1 on beat (4,6). Expect the beat is not counted,
//     out_valid=0 next cycle, busy=0, no done. A new start restarts at (0,1) stage 0.
//  5. start asserted during RUN and during DONE -> ignored: beat count stays 12 and a
//     single done pulse.
//  6. rst mid-run at beat 5 -> all outputs 0 next cycle; SAMPLES=2 case yields one beat
//     (0,1) with last=1, then done.

Source files
------------

// File: rtl/fft_butterfly_sched.sv
// Butterfly address scheduler for an in-place radix-2 FFT: walks all stages (DIT or DIF order)
// and emits one butterfly per accepted beat; 1-cycle start-to-first-beat, fields held while ready is low.
module fft_butterfly_sched #(
    parameter int SAMPLES = 16,
    parameter int MODE    = 0,
    localparam int LOG2  = $clog2(SAMPLES),
    localparam int IDX_W = (LOG2 > 1) ? LOG2 : 1,
    localparam int TW_W  = (LOG2 > 2) ? LOG2 - 1 : 1,
    localparam int STG_W = ($clog2(LOG2) > 1) ? $clog2(LOG2) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] idx_a,
    output logic [IDX_W-1:0] idx_b,
    output logic [TW_W-1:0]  tw_idx,
    output logic [STG_W-1:0] stage,
    output logic             last_in_stage,
    output logic             last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Pair counter spans SAMPLES/2 values, which needs exactly TW_W bits.
    localparam logic [TW_W-1:0]  P_MAX   = TW_W'(SAMPLES / 2 - 1);
    localparam logic [STG_W-1:0] S_FIRST = (MODE == 0) ? '0 : STG_W'(LOG2 - 1);
    localparam logic [STG_W-1:0] S_FINAL = (MODE == 0) ? STG_W'(LOG2 - 1) : '0;

    state_t           state_q, state_n;
    logic [TW_W-1:0]  p_q, p_n;
    logic [STG_W-1:0] s_q, s_n;
    logic             accept;

    logic [IDX_W-1:0] pe, jm, j_n, a_n, b_n, tw_full;
    logic [TW_W-1:0]  tw_n;
    logic             lis_n, last_n;

    assign accept = out_valid && out_ready;

    always_comb begin
        state_n = state_q;
        p_n     = p_q;
        s_n     = s_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    p_n     = '0;
                    s_n     = S_FIRST;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (accept) begin
                    if (last) begin
                        state_n = DONE;
                    end else if (p_q == P_MAX) begin
                        p_n = '0;
                        s_n = (MODE == 0) ? s_q + STG_W'(1) : s_q - STG_W'(1);
                    end else begin
                        p_n = p_q + TW_W'(1);
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Fields for the beat that will be presented next cycle; a 0 is spliced in at bit s.
    always_comb begin
        pe      = IDX_W'(p_n);
        jm      = (IDX_W'(1) << s_n) - IDX_W'(1);
        j_n     = pe & jm;
        a_n     = ((((pe >> s_n) << s_n)) << 1) | j_n;
        b_n     = a_n | (IDX_W'(1) << s_n);
        tw_full = j_n << (STG_W'(LOG2 - 1) - s_n);
        tw_n    = TW_W'(tw_full);
        lis_n   = (p_n == P_MAX);
        last_n  = lis_n && (s_n == S_FINAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            p_q           <= '0;
            s_q           <= '0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            idx_a         <= '0;
            idx_b         <= '0;
            tw_idx        <= '0;
            stage         <= '0;
            last_in_stage <= 1'b0;
            last          <= 1'b0;
        end else begin
            state_q   <= state_n;
            p_q       <= p_n;
            s_q       <= s_n;
            out_valid <= (state_n == RUN);
            busy      <= (state_n == RUN);
            done      <= (state_n == DONE);
            if (state_n == RUN) begin
                idx_a         <= a_n;
                idx_b         <= b_n;
                tw_idx        <= tw_n;
                stage         <= s_n;
                last_in_stage <= lis_n;
                last          <= last_n;
            end else begin
                idx_a         <= '0;
                idx_b         <= '0;
                tw_idx        <= '0;
                stage         <= '0;
                last_in_stage <= 1'b0;
                last          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_butterfly_sched.sv
// Bench for fft_butterfly_sched: three instances (8-pt DIT, 8-pt DIF, 2-pt) checked every cycle
// against a schedule-list model, with directed scenarios followed by randomized start/abort/ready/rst.
module tb_fft_butterfly_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start [3];
    logic abrt  [3];
    logic ready [3];
    logic vld [3], lis [3], lst [3], bsy [3], dn [3];

    logic [2:0] a0, b0, a1, b1;
    logic [1:0] tw0, tw1, st0, st1;
    logic       a2, b2, tw2, st2;

    fft_butterfly_sched #(.SAMPLES(8), .MODE(0)) u_dit (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abrt[0]), .out_valid(vld[0]),
        .out_ready(ready[0]), .idx_a(a0), .idx_b(b0), .tw_idx(tw0), .stage(st0),
        .last_in_stage(lis[0]), .last(lst[0]), .busy(bsy[0]), .done(dn[0]));

    fft_butterfly_sched #(.SAMPLES(8), .MODE(1)) u_dif (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abrt[1]), .out_valid(vld[1]),
        .out_ready(ready[1]), .idx_a(a1), .idx_b(b1), .tw_idx(tw1), .stage(st1),
        .last_in_stage(lis[1]), .last(lst[1]), .busy(bsy[1]), .done(dn[1]));

    fft_butterfly_sched #(.SAMPLES(2), .MODE(0)) u_two (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abrt[2]), .out_valid(vld[2]),
        .out_ready(ready[2]), .idx_a(a2), .idx_b(b2), .tw_idx(tw2), .stage(st2),
        .last_in_stage(lis[2]), .last(lst[2]), .busy(bsy[2]), .done(dn[2]));

    int da [3], db [3], dtw [3], dst [3];
    always_comb begin
        da[0] = int'(a0);  db[0] = int'(b0);  dtw[0] = int'(tw0); dst[0] = int'(st0);
        da[1] = int'(a1);  db[1] = int'(b1);  dtw[1] = int'(tw1); dst[1] = int'(st1);
        da[2] = int'(a2);  db[2] = int'(b2);  dtw[2] = int'(tw2); dst[2] = int'(st2);
    end

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
        bit lis;
        bit lst;
    } beat_t;

    beat_t sched [3][16];
    int    nb [3];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    chk_en = 1'b0;

    // Model state: running flag, index into the schedule list, pending done pulse.
    bit m_run [3];
    bit m_dn  [3];
    int m_k   [3];
    int acc   [3];
    int dones [3];

    // Schedule built from group/offset loops rather than bit splicing.
    function automatic void build(int i, int n, int mode);
        int lg, s, half, ngrp;
        lg    = $clog2(n);
        nb[i] = 0;
        for (int t = 0; t < lg; t++) begin
            s    = (mode != 0) ? lg - 1 - t : t;
            half = 1 << s;
            ngrp = n / (2 * half);
            for (int g = 0; g < ngrp; g++) begin
                for (int j = 0; j < half; j++) begin
                    sched[i][nb[i]].a   = g * 2 * half + j;
                    sched[i][nb[i]].b   = g * 2 * half + j + half;
                    sched[i][nb[i]].tw  = j * ((n / 2) / half);
                    sched[i][nb[i]].st  = s;
                    sched[i][nb[i]].lis = (g == ngrp - 1) && (j == half - 1);
                    sched[i][nb[i]].lst = (g == ngrp - 1) && (j == half - 1) && (t == lg - 1);
                    nb[i] = nb[i] + 1;
                end
            end
        end
    endfunction

    task automatic chk(string nm, int i, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_run[i] = 1'b0;
                m_dn[i]  = 1'b0;
                m_k[i]   = 0;
            end else if (m_run[i]) begin
                if (abrt[i]) begin
                    m_run[i] = 1'b0;
                end else if (ready[i]) begin
                    acc[i] = acc[i] + 1;
                    if (m_k[i] == nb[i] - 1) begin
                        m_run[i] = 1'b0;
                        m_dn[i]  = 1'b1;
                    end else begin
                        m_k[i] = m_k[i] + 1;
                    end
                end
            end else if (m_dn[i]) begin
                m_dn[i] = 1'b0;
            end else if (start[i]) begin
                m_run[i] = 1'b1;
                m_k[i]   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("out_valid", i, int'(vld[i]), int'(m_run[i]));
                chk("busy", i, int'(bsy[i]), int'(m_run[i]));
                chk("done", i, int'(dn[i]), int'(m_dn[i]));
                dones[i] = dones[i] + int'(dn[i]);
                if (m_run[i]) begin
                    chk("idx_a", i, da[i], sched[i][m_k[i]].a);
                    chk("idx_b", i, db[i], sched[i][m_k[i]].b);
                    chk("tw_idx", i, dtw[i], sched[i][m_k[i]].tw);
                    chk("stage", i, dst[i], sched[i][m_k[i]].st);
                    chk("last_in_stage", i, int'(lis[i]), int'(sched[i][m_k[i]].lis));
                    chk("last", i, int'(lst[i]), int'(sched[i][m_k[i]].lst));
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ab(int i, int a, int b);
        int t = 0;
        while (!(vld[i] && da[i] == a && db[i] == b) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("wait_beat_timeout", i, t, 0);
    endtask

    task automatic wait_done(int i);
        int t = 0;
        while (!dn[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("wait_done_timeout", i, t, 0);
    endtask

    int base_acc, base_dn;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; abrt[i] = 1'b0; ready[i] = 1'b1;
            m_run[i] = 1'b0; m_dn[i] = 1'b0; m_k[i] = 0; acc[i] = 0; dones[i] = 0;
        end
        build(0, 8, 0);
        build(1, 8, 1);
        build(2, 2, 0);

        // Pin the model with hand-derived entries.
        chk("model_nb", 0, nb[0], 12);
        chk("model_dit5_b", 0, sched[0][5].b, 3);
        chk("model_dit5_tw", 0, sched[0][5].tw, 2);
        chk("model_dit11_tw", 0, sched[0][11].tw, 3);
        chk("model_dif0_b", 1, sched[1][0].b, 4);
        chk("model_dif11_a", 1, sched[1][11].a, 6);
        chk("model_two_lst", 2, int'(sched[2][0].lst), 1);

        @(negedge clk);
        chk_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("rst_valid", 0, int'(vld[0]), 0);
        chk("rst_busy", 0, int'(bsy[0]), 0);
        chk("rst_done", 0, int'(dn[0]), 0);
        chk("rst_idx_b", 0, db[0], 0);
        chk("rst_last", 0, int'(lst[0]), 0);

        // DIT and DIF full runs; extra starts during RUN and DONE on the DIF instance.
        base_acc = acc[1];
        base_dn  = dones[1];
        start[0] = 1'b1; start[1] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; start[1] = 1'b0;
        chk("first_valid", 0, int'(vld[0]), 1);
        chk("first_b", 0, db[0], 1);
        chk("first_b", 1, db[1], 4);
        cyc(5);
        start[1] = 1'b1;
        cyc(1);
        start[1] = 1'b0;
        wait_done(1);
        start[1] = 1'b1;
        cyc(1);
        start[1] = 1'b0;
        cyc(3);
        chk("no_queued_start", 1, int'(vld[1]), 0);
        chk("dif_beats", 1, acc[1] - base_acc, 12);
        chk("dif_dones", 1, dones[1] - base_dn, 1);

        // Back-pressure on (1,3).
        base_acc = acc[0];
        base_dn  = dones[0];
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        wait_ab(0, 1, 3);
        ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("held_a", 0, da[0], 1);
            chk("held_b", 0, db[0], 3);
        end
        ready[0] = 1'b1;
        wait_done(0);
        cyc(1);
        chk("bp_beats", 0, acc[0] - base_acc, 12);
        chk("bp_dones", 0, dones[0] - base_dn, 1);

        // Abort on (4,6): six beats delivered before it, no done.
        base_acc = acc[0];
        base_dn  = dones[0];
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        wait_ab(0, 4, 6);
        abrt[0] = 1'b1;
        cyc(1);
        abrt[0] = 1'b0;
        chk("abort_valid", 0, int'(vld[0]), 0);
        chk("abort_busy", 0, int'(bsy[0]), 0);
        cyc(3);
        chk("abort_beats", 0, acc[0] - base_acc, 6);
        chk("abort_dones", 0, dones[0] - base_dn, 0);
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        chk("restart_a", 0, da[0], 0);
        chk("restart_b", 0, db[0], 1);
        chk("restart_stage", 0, dst[0], 0);

        // Reset mid-run at beat 5, (0,2).
        wait_ab(0, 0, 2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_valid", 0, int'(vld[0]), 0);
        chk("midrst_busy", 0, int'(bsy[0]), 0);
        chk("midrst_a", 0, da[0], 0);
        chk("midrst_b", 0, db[0], 0);
        chk("midrst_lis", 0, int'(lis[0]), 0);

        // Two-point transform: one beat then done.
        start[2] = 1'b1;
        cyc(1);
        start[2] = 1'b0;
        chk("two_valid", 2, int'(vld[2]), 1);
        chk("two_b", 2, db[2], 1);
        chk("two_last", 2, int'(lst[2]), 1);
        cyc(1);
        chk("two_done", 2, int'(dn[2]), 1);
        chk("two_valid_after", 2, int'(vld[2]), 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < 3; i++) begin
                start[i] = ($urandom_range(0, 7) == 0);
                abrt[i]  = ($urandom_range(0, 39) == 0);
                ready[i] = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; abrt[i] = 1'b0; ready[i] = 1'b1;
        end
        cyc(30);
        chk("drained", 0, int'(vld[0] | vld[1] | vld[2]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
